// File: rtl/siphash_pkg.sv
// Shared definitions for the SipHash message sequencer:
// FSM state encoding, default round counts and the length-byte position.
package siphash_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_COLLECT,
        S_COMP,
        S_COMP_WAIT,
        S_FIN,
        S_FIN_WAIT,
        S_DONE
    } state_e;

    localparam int unsigned C_ROUNDS_DEF = 2;
    localparam int unsigned D_ROUNDS_DEF = 4;
    localparam int unsigned LEN_POS      = 56;

endpackage

// File: rtl/siphash_byte_packer.sv
// Little-endian byte packer: lane write, zero pad and length-byte insert
// for the final SipHash word, plus the byte index and mod-256 length.
module siphash_byte_packer
    import siphash_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        wr,
    input  logic        last,
    input  logic [7:0]  data,
    input  logic        load_len,
    input  logic        clear_word,
    output logic [63:0] word,
    output logic [2:0]  idx
);

    logic [63:0] word_q, word_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  len_q, len_d;

    // Next word/index/length from the single active control
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        len_d  = len_q;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
            len_d  = '0;
        end else if (wr) begin
            len_d = len_q + 8'd1;
            idx_d = idx_q + 3'd1;
            for (int i = 0; i < 8; i++) begin
                if (3'(i) == idx_q) begin
                    word_d[8*i +: 8] = data;
                end else if (last && idx_q != 3'd7 && 3'(i) > idx_q) begin
                    word_d[8*i +: 8] = (i == 7) ? len_d : 8'h00;
                end
            end
        end else if (load_len) begin
            word_d = 64'(len_q) << LEN_POS;
            idx_d  = '0;
        end else if (clear_word) begin
            word_d = '0;
            idx_d  = '0;
        end
    end

    // Packer state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            idx_q  <= '0;
            len_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            len_q  <= len_d;
        end
    end

    assign word = word_q;
    assign idx  = idx_q;

endmodule

// File: rtl/siphash_msg_sequencer.sv
// Byte-stream front end driving siphash_core init/compress/finalize.
// Optional SIPHASH_SEQ_MSG_CNT_EN adds a saturating 32-bit msg_bytes count.
module siphash_msg_sequencer
    import siphash_pkg::*;
#(
    parameter int unsigned C_ROUNDS = C_ROUNDS_DEF,
    parameter int unsigned D_ROUNDS = D_ROUNDS_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         start_empty,
    input  logic [127:0] key,
    input  logic         long,
    output logic         busy,
    output logic         done,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         core_initalize,
    output logic         core_compress,
    output logic         core_finalize,
    output logic [63:0]  core_mi,
    output logic [127:0] core_key,
    output logic         core_long,
    output logic [3:0]   core_compression_rounds,
    output logic [3:0]   core_final_rounds,
`ifdef SIPHASH_SEQ_MSG_CNT_EN
    output logic [31:0]  msg_bytes,
`endif
    input  logic         core_ready,
    input  logic         core_word_valid
);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic         long_q, long_d;
    logic         empty_q, empty_d;
    logic         final_q, final_d;
    logic         pend_q, pend_d;
    logic         blind_q, blind_d;

    logic         pk_clear, pk_wr, pk_load, pk_cw;
    logic [2:0]   idx;

    siphash_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .wr         (pk_wr),
        .last       (in_last),
        .data       (in_data),
        .load_len   (pk_load),
        .clear_word (pk_cw),
        .word       (core_mi),
        .idx        (idx)
    );

    // Sequencer FSM: next state, core strobes and packer controls
    always_comb begin
        state_d        = state_q;
        key_d          = key_q;
        long_d         = long_q;
        empty_d        = empty_q;
        final_d        = final_q;
        pend_d         = pend_q;
        blind_d        = blind_q;
        core_initalize = 1'b0;
        core_compress  = 1'b0;
        core_finalize  = 1'b0;
        in_ready       = 1'b0;
        done           = 1'b0;
        pk_clear       = 1'b0;
        pk_wr          = 1'b0;
        pk_load        = 1'b0;
        pk_cw          = 1'b0;
        busy           = (state_q != S_IDLE) && (state_q != S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d    = key;
                    long_d   = long;
                    empty_d  = start_empty;
                    final_d  = 1'b0;
                    pend_d   = 1'b0;
                    pk_clear = 1'b1;
                    state_d  = S_INIT;
                end
            end
            S_INIT: begin
                if (core_ready) begin
                    core_initalize = 1'b1;
                    if (empty_q) begin
                        pk_load = 1'b1;
                        final_d = 1'b1;
                        state_d = S_COMP;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pk_wr = 1'b1;
                    if (in_last) begin
                        if (idx == 3'd7) pend_d = 1'b1;
                        else final_d = 1'b1;
                        state_d = S_COMP;
                    end else if (idx == 3'd7) begin
                        state_d = S_COMP;
                    end
                end
            end
            S_COMP: begin
                if (core_ready) begin
                    core_compress = 1'b1;
                    blind_d       = 1'b1;
                    state_d       = S_COMP_WAIT;
                end
            end
            S_COMP_WAIT: begin
                if (blind_q) begin
                    blind_d = 1'b0;
                end else if (core_ready) begin
                    if (final_q) begin
                        state_d = S_FIN;
                    end else if (pend_q) begin
                        pk_load = 1'b1;
                        pend_d  = 1'b0;
                        final_d = 1'b1;
                        state_d = S_COMP;
                    end else begin
                        pk_cw   = 1'b1;
                        state_d = S_COLLECT;
                    end
                end
            end
            S_FIN: begin
                if (core_ready) begin
                    core_finalize = 1'b1;
                    blind_d       = 1'b1;
                    state_d       = S_FIN_WAIT;
                end
            end
            S_FIN_WAIT: begin
                if (blind_q) begin
                    blind_d = 1'b0;
                end else if (core_ready && core_word_valid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            long_q  <= 1'b0;
            empty_q <= 1'b0;
            final_q <= 1'b0;
            pend_q  <= 1'b0;
            blind_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            long_q  <= long_d;
            empty_q <= empty_d;
            final_q <= final_d;
            pend_q  <= pend_d;
            blind_q <= blind_d;
        end
    end

    assign core_key                = key_q;
    assign core_long               = long_q;
    assign core_compression_rounds = 4'(C_ROUNDS);
    assign core_final_rounds       = 4'(D_ROUNDS);

`ifdef SIPHASH_SEQ_MSG_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    // Full saturating byte count of the current message
    always_comb begin
        cnt_d = cnt_q;
        if (pk_clear) cnt_d = '0;
        else if (pk_wr && cnt_q != 32'hffff_ffff) cnt_d = cnt_q + 32'd1;
    end

    // Byte count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign msg_bytes = cnt_q;
`endif

endmodule

// File: tb/tb_siphash_msg_sequencer.sv
// Directed bench for siphash_msg_sequencer with a behavioural core
// model that stalls ready after compress/finalize and logs each mi word.
module tb_siphash_msg_sequencer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start, start_empty, long;
    logic [127:0] key;
    logic         busy, done;
    logic         in_valid, in_ready, in_last;
    logic [7:0]   in_data;
    logic         core_initalize, core_compress, core_finalize;
    logic [63:0]  core_mi;
    logic [127:0] core_key;
    logic         core_long;
    logic [3:0]   core_compression_rounds, core_final_rounds;
    logic         core_ready, core_word_valid;
`ifdef SIPHASH_SEQ_MSG_CNT_EN
    logic [31:0]  msg_bytes;
`endif

    localparam logic [127:0] K1 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] K2 = 128'h1111222233334444aaaabbbbccccdddd;
    localparam logic [127:0] K3 = 128'hdeadbeef00000000cafef00d12345678;

    int checks = 0;
    int errors = 0;

    siphash_msg_sequencer dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .start                   (start),
        .start_empty             (start_empty),
        .key                     (key),
        .long                    (long),
        .busy                    (busy),
        .done                    (done),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_data                 (in_data),
        .in_last                 (in_last),
        .core_initalize          (core_initalize),
        .core_compress           (core_compress),
        .core_finalize           (core_finalize),
        .core_mi                 (core_mi),
        .core_key                (core_key),
        .core_long               (core_long),
        .core_compression_rounds (core_compression_rounds),
        .core_final_rounds       (core_final_rounds),
`ifdef SIPHASH_SEQ_MSG_CNT_EN
        .msg_bytes               (msg_bytes),
`endif
        .core_ready              (core_ready),
        .core_word_valid         (core_word_valid)
    );

    always #5 clk = ~clk;

    // core model
    int          lat = 2;
    int          cnt = 0;
    logic        strobe_d = 1'b0;
    logic        fin_d = 1'b0;
    logic        fin_done = 1'b0;
    int          n_init = 0, n_comp = 0, n_fin = 0, viol = 0;
    logic [63:0] mi_q[$];

    assign core_ready      = (cnt == 0);
    assign core_word_valid = fin_done && (cnt == 0);

    always @(posedge clk) begin
        strobe_d <= core_compress || core_finalize;
        fin_d    <= core_finalize;
        if (strobe_d) cnt <= lat;
        else if (cnt > 0) cnt <= cnt - 1;
        if (core_initalize) fin_done <= 1'b0;
        else if (fin_d) fin_done <= 1'b1;
        if (core_initalize) n_init++;
        if (core_compress) begin
            n_comp++;
            mi_q.push_back(core_mi);
        end
        if (core_finalize) n_fin++;
        if ((core_initalize || core_compress || core_finalize) && !core_ready) viol++;
        if (int'(core_initalize) + int'(core_compress) + int'(core_finalize) > 1) viol++;
        if (in_ready && (!busy || core_initalize || core_compress || core_finalize)) viol++;
    end

    // run bookkeeping
    int          s_init, s_comp, s_fin, s_viol, s_mi;
    int          tmo;
    bit          got_done;
    logic [63:0] exp_q[$];

    task automatic snap();
        s_init = n_init;
        s_comp = n_comp;
        s_fin  = n_fin;
        s_viol = viol;
        s_mi   = mi_q.size();
        tmo    = 0;
    endtask

    // reference SipHash message padding
    task automatic build_exp(input int n, input int base);
        logic [63:0] w;
        int k;
        exp_q.delete();
        w = '0;
        k = 0;
        for (int i = 0; i < n; i++) begin
            w[8*k +: 8] = 8'(base + i);
            k++;
            if (k == 8) begin
                exp_q.push_back(w);
                w = '0;
                k = 0;
            end
        end
        w[63:56] = 8'(n);
        exp_q.push_back(w);
    endtask

    task automatic do_start(input logic [127:0] k, input logic l, input logic emp);
        @(negedge clk);
        start = 1'b1;
        key = k;
        long = l;
        start_empty = emp;
        @(negedge clk);
        start = 1'b0;
        start_empty = 1'b0;
    endtask

    task automatic feed(input int from, input int to, input int total,
                        input int base, input bit rnd);
        int i;
        int g;
        bit acc;
        i = from;
        g = 0;
        while (i < to && g < 5000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = 8'(base + i);
            in_last  = (i == total - 1);
            #1;
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) i++;
            g++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (i < to) tmo++;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done !== 1'b1 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        got_done = (done === 1'b1) && (tmo == 0);
        @(negedge clk);
    endtask

    task automatic run_msg(input int n, input int base, input bit rnd,
                           input logic [127:0] k, input logic l);
        snap();
        do_start(k, l, n == 0);
        feed(0, n, n, base, rnd);
        wait_done();
        build_exp(n, base);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        start_empty = 1'b0;
        key = '0;
        long = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b done=%b in_ready=%b exp 0 0 0",
                     busy, done, in_ready);
        end
        checks++;
        if ({core_initalize, core_compress, core_finalize} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=000",
                     {core_initalize, core_compress, core_finalize});
        end
        checks++;
        if (core_mi !== 64'h0 || core_key !== 128'h0 || core_long !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got mi=%h key=%h long=%b exp zeros",
                     core_mi, core_key, core_long);
        end
        checks++;
        if (core_compression_rounds !== 4'd2 || core_final_rounds !== 4'd4) begin
            errors++;
            $display("FAIL rounds got c=%0d d=%0d exp c=2 d=4",
                     core_compression_rounds, core_final_rounds);
        end
`ifdef SIPHASH_SEQ_MSG_CNT_EN
        checks++;
        if (msg_bytes !== 32'd0) begin
            errors++;
            $display("FAIL reset_msg_bytes got=%0d exp=0", msg_bytes);
        end
`endif
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty();
        lat = 2;
        run_msg(0, 0, 1'b0, K1, 1'b0);
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL empty_done got=0 exp=1");
        end
        checks++;
        if (n_comp - s_comp != 1 || n_fin - s_fin != 1 || n_init - s_init != 1) begin
            errors++;
            $display("FAIL empty_strobes got init=%0d comp=%0d fin=%0d exp 1 1 1",
                     n_init - s_init, n_comp - s_comp, n_fin - s_fin);
        end
        checks++;
        if (mi_q.size() <= s_mi || mi_q[s_mi] !== 64'h0) begin
            errors++;
            $display("FAIL empty_mi got=%h exp=0",
                     (mi_q.size() > s_mi) ? mi_q[s_mi] : 64'hx);
        end
        checks++;
        if (core_key !== K1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_key got key=%h busy=%b exp key=%h busy=0",
                     core_key, busy, K1);
        end
    endtask

    task automatic test_15_bytes();
        lat = 3;
        run_msg(15, 0, 1'b0, K1, 1'b0);
        checks++;
        if (!got_done || n_comp - s_comp != 2 || n_fin - s_fin != 1) begin
            errors++;
            $display("FAIL b15_count got done=%b comp=%0d fin=%0d exp 1 2 1",
                     got_done, n_comp - s_comp, n_fin - s_fin);
        end
        checks++;
        if (mi_q.size() < s_mi + 2 || mi_q[s_mi] !== 64'h0706050403020100
            || mi_q[s_mi+1] !== 64'h0f0e0d0c0b0a0908) begin
            errors++;
            $display("FAIL b15_words got size=%0d exp 0706050403020100,0f0e0d0c0b0a0908",
                     mi_q.size() - s_mi);
        end
    endtask

    task automatic test_8_bytes();
        lat = 2;
        run_msg(8, 0, 1'b0, K1, 1'b0);
        checks++;
        if (!got_done || n_comp - s_comp != 2 || n_fin - s_fin != 1) begin
            errors++;
            $display("FAIL b8_count got done=%b comp=%0d fin=%0d exp 1 2 1",
                     got_done, n_comp - s_comp, n_fin - s_fin);
        end
        checks++;
        if (mi_q.size() < s_mi + 2 || mi_q[s_mi] !== 64'h0706050403020100
            || mi_q[s_mi+1] !== 64'h0800000000000000) begin
            errors++;
            $display("FAIL b8_words got size=%0d exp 0706050403020100,0800000000000000",
                     mi_q.size() - s_mi);
        end
    endtask

    task automatic test_stall();
        int bad;
        lat = 6;
        run_msg(20, 8'h30, 1'b1, K2, 1'b1);
        bad = 0;
        for (int j = 0; j < exp_q.size(); j++)
            if (mi_q.size() <= s_mi + j || mi_q[s_mi+j] !== exp_q[j]) bad++;
        checks++;
        if (!got_done || bad != 0 || mi_q.size() - s_mi != exp_q.size()) begin
            errors++;
            $display("FAIL stall_words got done=%b bad=%0d words=%0d exp done=1 bad=0 words=%0d",
                     got_done, bad, mi_q.size() - s_mi, exp_q.size());
        end
        checks++;
        if (viol != s_viol) begin
            errors++;
            $display("FAIL stall_protocol got violations=%0d exp=0", viol - s_viol);
        end
        checks++;
        if (core_long !== 1'b1 || core_key !== K2) begin
            errors++;
            $display("FAIL stall_passthru got long=%b key=%h exp long=1 key=%h",
                     core_long, core_key, K2);
        end
    endtask

    task automatic test_300();
        int bad;
        lat = 1;
        run_msg(300, 0, 1'b0, K1, 1'b0);
        bad = 0;
        for (int j = 0; j < exp_q.size(); j++)
            if (mi_q.size() <= s_mi + j || mi_q[s_mi+j] !== exp_q[j]) bad++;
        checks++;
        if (!got_done || n_comp - s_comp != 38 || bad != 0) begin
            errors++;
            $display("FAIL b300_words got done=%b comp=%0d bad=%0d exp 1 38 0",
                     got_done, n_comp - s_comp, bad);
        end
        checks++;
        if (mi_q.size() < s_mi + 38 || mi_q[s_mi+37][63:56] !== 8'h2c) begin
            errors++;
            $display("FAIL b300_lenbyte got=%h exp=2c",
                     (mi_q.size() >= s_mi + 38) ? mi_q[s_mi+37][63:56] : 8'hxx);
        end
`ifdef SIPHASH_SEQ_MSG_CNT_EN
        checks++;
        if (msg_bytes !== 32'd300) begin
            errors++;
            $display("FAIL b300_msg_bytes got=%0d exp=300", msg_bytes);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int bad;
        lat = 2;
        snap();
        do_start(K2, 1'b1, 1'b0);
        feed(0, 3, 10, 8'h90, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || core_mi !== 64'h0
            || core_key !== 128'h0 || core_long !== 1'b0) begin
            errors++;
            $display("FAIL midreset got busy=%b in_ready=%b mi=%h long=%b exp zeros",
                     busy, in_ready, core_mi, core_long);
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_msg(5, 8'h50, 1'b0, K1, 1'b0);
        bad = 0;
        for (int j = 0; j < exp_q.size(); j++)
            if (mi_q.size() <= s_mi + j || mi_q[s_mi+j] !== exp_q[j]) bad++;
        checks++;
        if (!got_done || bad != 0 || n_comp - s_comp != 1) begin
            errors++;
            $display("FAIL midreset_rerun got done=%b bad=%0d comp=%0d exp 1 0 1",
                     got_done, bad, n_comp - s_comp);
        end
    endtask

    task automatic test_start_busy();
        int bad;
        lat = 2;
        snap();
        do_start(K2, 1'b0, 1'b0);
        feed(0, 4, 6, 8'h20, 1'b0);
        do_start(K3, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b1 || core_key !== K2 || core_long !== 1'b0) begin
            errors++;
            $display("FAIL busy_start got busy=%b key=%h long=%b exp busy=1 key=%h long=0",
                     busy, core_key, core_long, K2);
        end
        feed(4, 6, 6, 8'h20, 1'b0);
        wait_done();
        build_exp(6, 8'h20);
        bad = 0;
        for (int j = 0; j < exp_q.size(); j++)
            if (mi_q.size() <= s_mi + j || mi_q[s_mi+j] !== exp_q[j]) bad++;
        checks++;
        if (!got_done || bad != 0 || n_comp - s_comp != 1 || n_init - s_init != 1) begin
            errors++;
            $display("FAIL busy_start_msg got done=%b bad=%0d comp=%0d init=%0d exp 1 0 1 1",
                     got_done, bad, n_comp - s_comp, n_init - s_init);
        end
        run_msg(9, 8'hf8, 1'b1, K3, 1'b0);
        bad = 0;
        for (int j = 0; j < exp_q.size(); j++)
            if (mi_q.size() <= s_mi + j || mi_q[s_mi+j] !== exp_q[j]) bad++;
        checks++;
        if (!got_done || bad != 0 || n_comp - s_comp != 2 || core_key !== K3) begin
            errors++;
            $display("FAIL next_start got done=%b bad=%0d comp=%0d exp 1 0 2",
                     got_done, bad, n_comp - s_comp);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL protocol_total got violations=%0d exp=0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_15_bytes();
        test_8_bytes();
        test_stall();
        test_300();
        test_reset_mid();
        test_start_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/siphash_msg_sequencer.md
Name: siphash_msg_sequencer

Overview:
Front-end initiator for siphash_core. Accepts a message as a byte stream with valid/ready handshake, packs bytes little-endian into 64-bit words, and appends the SipHash final word (trailing bytes plus length mod 256 in byte 7). Drives the core's initalize/compress/finalize strobes against its ready signal and raises a done pulse when the tag is valid. Sits between the bus wrapper/DMA byte source and siphash_core.

Parameters:
C_ROUNDS, 2, value driven on core_compression_rounds (4 bits).
D_ROUNDS, 4, value driven on core_final_rounds (4 bits).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin message; samples key, long, start_empty
start_empty  in  1  with start: zero-length message, no bytes follow
key  in  128  SipHash key, passed through to core
long  in  1  128-bit tag mode, passed through to core
busy  out  1  sequence in progress
done  out  1  one-cycle pulse: tag valid in core
in_valid  in  1  byte valid
in_ready  out  1  byte accepted when in_valid&&in_ready
in_data  in  8  message byte
in_last  in  1  marks final byte
core_initalize  out  1  one-cycle strobe
core_compress  out  1  one-cycle strobe
core_finalize  out  1  one-cycle strobe
core_mi  out  64  registered message word
core_key  out  128  registered key
core_long  out  1  registered long
core_compression_rounds  out  4  C_ROUNDS
core_final_rounds  out  4  D_ROUNDS
core_ready  in  1  core ready
core_word_valid  in  1  core tag valid

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy, done, in_ready, all strobes 0; core_mi, core_key, core_long, byte index, length counter cleared.
- States: IDLE, INIT, COLLECT, COMP, COMP_WAIT, FIN, FIN_WAIT, DONE.
- IDLE: start=1 latches key/long/start_empty, clears length (8 bits) and byte index (3 bits), busy=1 -> INIT. start while busy is ignored.
- INIT: core_initalize=1 for one cycle. Next state: COMP with final word {8'h00,56'h0} if start_empty, else COLLECT.
- COLLECT: in_ready=1. Accepted byte is written to core_mi[8*idx+:8]; idx+1 and length+1, both modulo wrap.
  - idx==7 && !in_last -> COMP; word is full.
  - in_last with idx<7 -> pad bytes idx+1..6 with 0; byte 7 = length+1 (mod 256); word is final -> COMP.
  - in_last with idx==7 -> COMP with full word; last_pending=1.
- COMP: core_compress=1 for exactly one cycle (core_ready is 1 on entry) -> COMP_WAIT.
- COMP_WAIT:
  - Ignore core_ready in the first cycle (core drops ready one cycle after the strobe).
  - Afterwards wait for core_ready=1, then:
    - final word sent -> FIN;
    - last_pending -> load {length,56'h0}, clear last_pending, mark word final -> COMP;
    - otherwise clear core_mi, idx=0 -> COLLECT.
- FIN: core_finalize=1 one cycle -> FIN_WAIT. Same one-cycle blind window, then wait core_ready=1 && core_word_valid=1 -> DONE.
- DONE: done=1 one cycle, busy=0 -> IDLE.
- Length is total bytes mod 256; the upper bits are irrelevant to the algorithm. in_ready is 0 in every state except COLLECT. Strobes are mutually exclusive and never asserted while core_ready=0.
- Latency for N≥1 bytes: 1 (INIT) + N + ceil((N+1)/8) x (1 + core compress time) + finalize time + 1.

Optional Feature:
SIPHASH_SEQ_MSG_CNT_EN: when defined, adds output msg_bytes[31:0]. It holds the full (non-wrapping, saturating at 32'hffffffff) byte count of the current/last message, cleared on start, reset 0. When undefined, the port and counter are absent and only the 8-bit mod-256 length exists.

Decomposition:
- Shared package siphash_pkg: state encodings, C_ROUNDS/D_ROUNDS defaults, the length-byte position constant (56).
- One natural sub-module, siphash_byte_packer: byte index, lane write, zero pad, length-byte insert, with load/clear controls. FSM stays in the top.

Test Plan:
- With siphash_core attached, key=0x0f0e..0100 (key[63:0]=64'h0706050403020100), start_empty=1 -> one compress with mi=0, then done; tag[63:0]=64'h726fdb47dd0e0e31.
- Same key, 15 bytes 00..0e -> mi sequence 64'h0706050403020100, 64'h0f0e0d0c0b0a0908; tag 64'ha129ca6149be45e5.
- 8 bytes 00..07 -> mi 64'h0706050403020100 then 64'h0800000000000000 (last_pending path); 2 compresses, 1 finalize.
- in_valid toggling randomly, core_ready held low extra cycles -> no strobe while core_ready=0, in_ready=0 outside COLLECT, identical tag.
- 300-byte message -> final word byte 7 = 8'h2c (300 mod 256); with SIPHASH_SEQ_MSG_CNT_EN, msg_bytes=300.
- reset_n pulsed low mid-COLLECT -> outputs 0 immediately; start issued while busy is ignored, and the next start runs cleanly.
